twos_inc_seq: RTL and testbench

- Parametrised, multi-cycle successor to the team's 4-bit carry-lookahead incrementer.
- Adds a carry-in to a WIDTH-bit operand, processing one CHUNK-bit lookahead slice per clock.
- Terminates early once the carry dies, so typical latency is low.
- Supports increment, negate, abs and ones-complement modes with a valid/ready handshake on each side.
- Used by the FP ALU for mantissa negation and rounding increment.

---
 rtl/twos_inc_seq.sv | 131 +++++++++++++
 tb/tb_twos_inc_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_inc_seq.sv
// Multi-cycle incrementer/negator: resolves one CHUNK-bit lookahead slice per clock and stops
// as soon as the carry dies. Supports A+cin, negate, abs and ones-complement modes.
module twos_inc_seq #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [IW-1:0]    idx;

    logic             load_inv;
    logic             load_carry;
    logic [WIDTH-1:0] load_work;
    logic             load_ovf;

    logic [IW-1:0]    cur_idx;
    int unsigned      base;
    logic [WIDTH-1:0] src_work;
    logic             src_carry;
    logic [CHUNK-1:0] slice;
    logic [CHUNK-1:0] new_slice;
    logic             run;
    logic             slice_cout;
    logic [WIDTH-1:0] next_work;
    logic             finish;

    always_comb begin
        load_inv = (mode == 2'b01) || (mode == 2'b11) || ((mode == 2'b10) && a[WIDTH-1]);
        load_work = load_inv ? ~a : a;
        load_ovf = ((mode == 2'b01) || (mode == 2'b10)) && (a == MIN_NEG);
        case (mode)
            2'b00:   load_carry = cin;
            2'b01:   load_carry = 1'b1;
            2'b10:   load_carry = a[WIDTH-1];
            default: load_carry = 1'b0;
        endcase
    end

    // Slice 0 is resolved on the accept edge itself, so latency is 1 + first non-all-ones slice.
    always_comb begin
        cur_idx   = (state == IDLE) ? '0 : idx;
        src_work  = (state == IDLE) ? load_work : work;
        src_carry = (state == IDLE) ? load_carry : 1'b1;
        base      = 32'(cur_idx) * CHUNK;
        slice     = src_work[base +: CHUNK];
        run       = src_carry;
        new_slice = '0;
        for (int j = 0; j < CHUNK; j++) begin
            new_slice[j] = slice[j] ^ run;
            run          = run & slice[j];
        end
        slice_cout = run;
        next_work  = src_work;
        next_work[base +: CHUNK] = new_slice;
        finish = !slice_cout || (cur_idx == LAST_IDX);
    end

    assign in_ready = (state == IDLE) && !rst;
    assign zero     = out_valid && (result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ovf <= load_ovf;
                        if (finish) begin
                            state     <= DONE;
                            result    <= next_work;
                            cout      <= slice_cout;
                            out_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                            work  <= next_work;
                            idx   <= IW'(1);
                        end
                    end
                end
                RUN: begin
                    if (finish) begin
                        state     <= DONE;
                        result    <= next_work;
                        cout      <= slice_cout;
                        out_valid <= 1'b1;
                    end else begin
                        work <= next_work;
                        idx  <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_inc_seq.sv
// Self-checking bench for twos_inc_seq: arithmetic reference model with a per-cycle checker,
// plus directed vectors with hand-computed results and latencies.
module tb_twos_inc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'b00;
    logic [23:0] a = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    twos_inc_seq #(.WIDTH(24), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .a(a),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout),
        .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic; latency from the first non-all-ones 4-bit slice.
    function automatic void model(input logic [1:0] md, input logic [23:0] av, input logic ci,
                                  output logic [23:0] r, output logic co, output logic ov,
                                  output int lat);
        logic [24:0] s;
        logic [23:0] w;
        logic        c;
        bit          found;
        case (md)
            2'd0:    s = {1'b0, av} + {24'd0, ci};
            2'd1:    s = {1'b0, ~av} + 25'd1;
            2'd2:    s = av[23] ? ({1'b0, ~av} + 25'd1) : {1'b0, av};
            default: s = {1'b0, ~av};
        endcase
        r  = s[23:0];
        co = s[24];
        ov = ((md == 2'd1) || (md == 2'd2)) && (av == 24'h800000);
        w  = ((md == 2'd1) || (md == 2'd3) || ((md == 2'd2) && av[23])) ? ~av : av;
        c  = (md == 2'd0) ? ci : (md == 2'd1) ? 1'b1 : (md == 2'd2) ? av[23] : 1'b0;
        lat = 6;
        found = 1'b0;
        if (!c) lat = 1;
        else begin
            for (int i = 0; i < 6; i++) begin
                if (!found && (w[i*4 +: 4] != 4'hF)) begin
                    lat = i + 1;
                    found = 1'b1;
                end
            end
        end
    endfunction

    logic [23:0] c_res;
    logic        c_cout, c_ovf;
    int          c_lat;
    always_comb model(mode, a, cin, c_res, c_cout, c_ovf, c_lat);

    // Model state: 0 idle, 1 busy, 2 result presented.
    int          m_st;
    int          m_rem;
    logic [23:0] m_res;
    logic        m_cout, m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  <= 0;
            m_rem <= 0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_res  <= c_res;
                    m_cout <= c_cout;
                    m_ovf  <= c_ovf;
                    m_rem  <= c_lat - 1;
                    m_st   <= (c_lat == 1) ? 2 : 1;
                end
                1: begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_st <= 2;
                end
                default: if (out_ready) m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("mon_in_ready", 32'(in_ready), 32'(m_st == 0));
            chk("mon_out_valid", 32'(out_valid), 32'(m_st == 2));
            if (m_st == 2) begin
                chk("mon_result", 32'(result), 32'(m_res));
                chk("mon_cout", 32'(cout), 32'(m_cout));
                chk("mon_zero", 32'(zero), 32'(m_res == 24'd0));
                chk("mon_ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    task automatic wait_out(output int n);
        bit got = 1'b0;
        n = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        if (!got) chk("timeout_out_valid", 32'(0), 32'(1));
    endtask

    task automatic do_op(input logic [1:0] md, input logic [23:0] av, input logic ci,
                         input bit pin, input logic [23:0] er, input logic ec, input logic ez,
                         input logic eo, input int el);
        int n = 0;
        logic [23:0] r;
        logic co, ov;
        int l;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        mode = md; a = av; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        if (pin) begin
            chk("lit_latency", 32'(n), 32'(el));
            chk("lit_result", 32'(result), 32'(er));
            chk("lit_cout", 32'(cout), 32'(ec));
            chk("lit_zero", 32'(zero), 32'(ez));
            chk("lit_ovf", 32'(ovf), 32'(eo));
            model(md, av, ci, r, co, ov, l);
            chk("model_result", 32'(r), 32'(er));
            chk("model_latency", 32'(l), 32'(el));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [23:0] held;
    int          n5;

    initial begin
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_cout_zero_ovf", {29'd0, cout, zero, ovf}, 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        do_op(2'd0, 24'h000FFF, 1'b1, 1'b1, 24'h001000, 1'b0, 1'b0, 1'b0, 4);
        do_op(2'd1, 24'h000001, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        do_op(2'd1, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0, 6);
        do_op(2'd2, 24'h800000, 1'b0, 1'b1, 24'h800000, 1'b0, 1'b0, 1'b1, 6);
        do_op(2'd2, 24'h7FFFFF, 1'b0, 1'b1, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 1);
        do_op(2'd2, 24'hFFFFFE, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b0, 1'b0, 1);
        do_op(2'd3, 24'h0F0F0F, 1'b0, 1'b1, 24'hF0F0F0, 1'b0, 1'b0, 1'b0, 1);
        do_op(2'd0, 24'hFFFFFF, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0, 6);
        do_op(2'd1, 24'h800000, 1'b0, 1'b1, 24'h800000, 1'b0, 1'b0, 1'b1, 6);
        do_op(2'd0, 24'h0000FF, 1'b1, 1'b1, 24'h000100, 1'b0, 1'b0, 1'b0, 3);
        do_op(2'd0, 24'h123456, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 0);
        do_op(2'd1, 24'h0FFFF0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 0);
        do_op(2'd2, 24'hF00000, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 0);

        // Backpressure in DONE: inputs must be ignored and the result must hold.
        @(negedge clk);
        mode = 2'd0; a = 24'h00000F; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n5);
        chk("bp_latency", 32'(n5), 32'(2));
        held = result;
        chk("bp_result", 32'(held), 32'(24'h000010));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            mode = 2'(i);
            a = 24'hA5A5A5 ^ 24'(i * 24'h111111);
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_result", 32'(result), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_out_valid", 32'(out_valid), 32'(1));
        end
        mode = 2'd3; a = 24'h123456; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bubble_in_ready", 32'(in_ready), 32'(1));
        chk("bubble_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n5);
        chk("after_bubble_latency", 32'(n5), 32'(1));
        chk("after_bubble_result", 32'(result), 32'(24'hEDCBA9));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during RUN of a six-slice negate.
        mode = 2'd1; a = 24'h000000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_result", 32'(result), 32'(0));
        chk("midrst_flags", {29'd0, cout, zero, ovf}, 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'(1));
        chk("postrst_out_valid", 32'(out_valid), 32'(0));
        do_op(2'd0, 24'h00FFFF, 1'b1, 1'b1, 24'h010000, 1'b0, 1'b0, 1'b0, 5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
